// File: rtl/life_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : life_engine_if
// Description : Controller <-> life_engine bundle: seed load handshake,
//               step/run controls, and grid/generation status.
// Revision    : 1.0 - initial release
// ============================================================================
interface life_engine_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
);
    logic                   load_valid;
    logic                   load_ready;
    logic [ROWS*COLS-1:0]   load_grid;
    logic                   step;
    logic                   run;
    logic [ROWS*COLS-1:0]   grid_out;
    logic [GEN_W-1:0]       gen_count;
    logic                   gen_valid;
    logic                   busy;
    logic                   stable;
    logic                   extinct;

    // Controller side
    modport master (
        output load_valid, load_grid, step, run,
        input  load_ready, grid_out, gen_count, gen_valid, busy, stable, extinct
    );

    // Engine side
    modport slave (
        input  load_valid, load_grid, step, run,
        output load_ready, grid_out, gen_count, gen_valid, busy, stable, extinct
    );
endinterface
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Clocked R x C Game-of-Life engine with configurable edge
//               mode and birth/survive rules, single-step / free-run control,
//               generation counter and stable/extinct status.
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine #(
    parameter int       ROWS         = 8,
    parameter int       COLS         = 8,
    parameter int       WRAP         = 0,
    parameter bit [8:0] BIRTH_MASK   = 9'b000001000,
    parameter bit [8:0] SURVIVE_MASK = 9'b000001100,
    parameter int       GEN_W        = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,        // asynchronous, active-low
    life_engine_if.slave    bus
);
    localparam int c_CELLS = ROWS * COLS;
    // Rule masks padded to 16 entries so a 4-bit count indexes them exactly
    localparam bit [15:0] c_BIRTH16 = {7'd0, BIRTH_MASK};
    localparam bit [15:0] c_SURV16  = {7'd0, SURVIVE_MASK};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CELLS-1:0]   r_grid;
    logic [c_CELLS-1:0]   w_nxt;
    logic [GEN_W-1:0]     r_gen;
    logic                 r_gen_valid;
    logic                 r_stable;
    logic                 r_extinct;
    logic                 w_same;
    logic                 w_sat;
    logic                 w_do_load;
    logic                 w_do_adv;
    logic                 w_set_stable;

    // Per-cell successor: neighbour positions are resolved at elaboration,
    // so the datapath is just 8 taps, a popcount and a rule-mask lookup.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic [8:0] w_nb;
            logic [3:0] w_cnt;
            for (genvar gk = 0; gk < 9; gk++) begin : g_nb
                localparam int DR     = gk / 3 - 1;
                localparam int DC     = gk % 3 - 1;
                localparam int RR     = gr + DR;
                localparam int CC     = gc + DC;
                localparam int RW     = (RR + ROWS) % ROWS;
                localparam int CW     = (CC + COLS) % COLS;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                // Centre tap (gk==4) is the cell itself and never counts
                localparam bit USE    = (gk != 4) && ((WRAP != 0) || INSIDE);
                assign w_nb[gk] = USE ? r_grid[RW*COLS + CW] : 1'b0;
            end
            // Count live neighbours (0..8)
            always_comb begin
                w_cnt = 4'd0;
                for (int k = 0; k < 9; k++) begin
                    w_cnt = w_cnt + {3'd0, w_nb[k]};
                end
            end
            assign w_nxt[gr*COLS + gc] = r_grid[gr*COLS + gc] ? c_SURV16[w_cnt]
                                                              : c_BIRTH16[w_cnt];
        end
    end

    assign w_same = (w_nxt == r_grid);
    assign w_sat  = &r_gen;

    // Next-state and per-cycle action decode (load > run > step)
    always_comb begin
        w_state_nxt  = r_state;
        w_do_load    = 1'b0;
        w_do_adv     = 1'b0;
        w_set_stable = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_valid) begin
                    w_do_load = 1'b1;
                end else if (bus.run) begin
                    w_state_nxt = S_RUN;
                end else if (bus.step) begin
                    if (w_same) begin
                        w_set_stable = 1'b1;
                    end else if (!w_sat) begin
                        w_do_adv = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_same) begin
                    w_set_stable = 1'b1;
                    w_state_nxt  = S_HALT;
                end else if (w_sat) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_do_adv = 1'b1;
                end
            end
            S_HALT: begin
                if (bus.load_valid) begin
                    w_do_load   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grid, generation counter and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grid      <= '0;
            r_gen       <= '0;
            r_gen_valid <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b1;
        end else begin
            r_gen_valid <= w_do_adv;
            if (w_do_load) begin
                r_grid    <= bus.load_grid;
                r_gen     <= '0;
                r_stable  <= 1'b0;
                r_extinct <= (bus.load_grid == '0);
            end else if (w_do_adv) begin
                r_grid    <= w_nxt;
                r_gen     <= r_gen + 1'b1;
                r_stable  <= 1'b0;
                r_extinct <= (w_nxt == '0);
            end else if (w_set_stable) begin
                r_stable  <= 1'b1;
            end
        end
    end

    assign bus.load_ready = (r_state != S_RUN);
    assign bus.busy       = (r_state == S_RUN);
    assign bus.grid_out   = r_grid;
    assign bus.gen_count  = r_gen;
    assign bus.gen_valid  = r_gen_valid;
    assign bus.stable     = r_stable;
    assign bus.extinct    = r_extinct;
endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_engine
// Description : Self-checking bench for life_engine: table of seed/step
//               vectors plus hand-written run, saturation, priority and
//               asynchronous-reset sequences. Three instances cover
//               WRAP=0, WRAP=1 and a 2-bit generation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) b0 ();
    life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) b1 ();
    life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(2))  b2 ();

    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(2))  u2 (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        int           sel;
        logic [63:0]  seed;
        int           steps;
        logic [63:0]  exp_grid;
        logic [15:0]  exp_gen;
        logic         exp_stable;
        logic         exp_extinct;
    } vec_t;

    vec_t vecs[7];

    // Sampled outputs
    logic [63:0] s_grid;
    logic [15:0] s_gen;
    logic        s_gv, s_busy, s_stable, s_ext, s_lr;

    function automatic logic [63:0] cells(input int a, input int b = -1, input int c = -1,
                                          input int d = -1, input int e = -1);
        logic [63:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic lv, input logic [63:0] lg,
                          input logic st, input logic rn);
        case (sel)
            0: begin b0.load_valid = lv; b0.load_grid = lg; b0.step = st; b0.run = rn; end
            1: begin b1.load_valid = lv; b1.load_grid = lg; b1.step = st; b1.run = rn; end
            default: begin b2.load_valid = lv; b2.load_grid = lg; b2.step = st; b2.run = rn; end
        endcase
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin
                s_grid = b0.grid_out; s_gen = b0.gen_count; s_gv = b0.gen_valid;
                s_busy = b0.busy; s_stable = b0.stable; s_ext = b0.extinct; s_lr = b0.load_ready;
            end
            1: begin
                s_grid = b1.grid_out; s_gen = b1.gen_count; s_gv = b1.gen_valid;
                s_busy = b1.busy; s_stable = b1.stable; s_ext = b1.extinct; s_lr = b1.load_ready;
            end
            default: begin
                s_grid = b2.grid_out; s_gen = {14'd0, b2.gen_count}; s_gv = b2.gen_valid;
                s_busy = b2.busy; s_stable = b2.stable; s_ext = b2.extinct; s_lr = b2.load_ready;
            end
        endcase
    endtask

    task automatic load(input int sel, input logic [63:0] seed);
        @(negedge clk);
        set_in(sel, 1'b1, seed, 1'b0, 1'b0);
        @(negedge clk);
        set_in(sel, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic do_step(input int sel, inout int gv_cnt);
        @(negedge clk);
        set_in(sel, 1'b0, 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(sel, 1'b0, 64'd0, 1'b0, 1'b0);
        sample(sel);
        if (s_gv) gv_cnt++;
    endtask

    logic [63:0] blink_h, blink_v, block, corners, glider;
    int gv_cnt;

    initial begin
        blink_h = cells(26, 27, 28);
        blink_v = cells(19, 27, 35);
        block   = cells(27, 28, 35, 36);
        corners = cells(0, 7, 56, 63);
        glider  = cells(1, 10, 16, 17, 18);

        vecs[0] = '{"blinker_step1", 0, blink_h, 1, blink_v, 16'd1, 1'b0, 1'b0};
        vecs[1] = '{"blinker_step2", 0, blink_h, 2, blink_h, 16'd2, 1'b0, 1'b0};
        vecs[2] = '{"corners_dead",  0, corners, 1, 64'd0,   16'd1, 1'b0, 1'b1};
        vecs[3] = '{"corners_torus", 1, corners, 1, corners, 16'd0, 1'b1, 1'b0};
        vecs[4] = '{"block_step",    0, block,   1, block,   16'd0, 1'b1, 1'b0};
        vecs[5] = '{"lone_cell",     0, cells(27), 1, 64'd0, 16'd1, 1'b0, 1'b1};
        vecs[6] = '{"empty_step",    0, 64'd0,   1, 64'd0,   16'd0, 1'b1, 1'b1};

        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 64'd0, 1'b0, 1'b0);

        // Reset values while rst is held low
        #12;
        sample(0);
        chk("rst_grid",   s_grid,   64'd0);
        chk("rst_gen",    s_gen,    64'd0);
        chk("rst_gv",     s_gv,     64'd0);
        chk("rst_busy",   s_busy,   64'd0);
        chk("rst_stable", s_stable, 64'd0);
        chk("rst_extinct",s_ext,    64'd1);
        chk("rst_ready",  s_lr,     64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven seed/step vectors
        for (int i = 0; i < 7; i++) begin
            load(vecs[i].sel, vecs[i].seed);
            gv_cnt = 0;
            for (int k = 0; k < vecs[i].steps; k++) do_step(vecs[i].sel, gv_cnt);
            sample(vecs[i].sel);
            chk({vecs[i].name, "_grid"},    s_grid,   vecs[i].exp_grid);
            chk({vecs[i].name, "_gen"},     s_gen,    64'(vecs[i].exp_gen));
            chk({vecs[i].name, "_stable"},  s_stable, 64'(vecs[i].exp_stable));
            chk({vecs[i].name, "_extinct"}, s_ext,    64'(vecs[i].exp_extinct));
            chk({vecs[i].name, "_gvpulses"}, 64'(gv_cnt), 64'(vecs[i].exp_gen));
            @(negedge clk);
            sample(vecs[i].sel);
            chk({vecs[i].name, "_gvlow"},   s_gv,     64'd0);
        end

        // Block still life under run: HALT after two edges, no advance
        load(0, block);
        set_in(0, 1'b0, 64'd0, 1'b0, 1'b1);
        gv_cnt = 0;
        @(negedge clk);
        sample(0);
        if (s_gv) gv_cnt++;
        chk("block_run_busy1", s_busy, 64'd1);
        @(negedge clk);
        sample(0);
        if (s_gv) gv_cnt++;
        chk("block_halt_busy",   s_busy,   64'd0);
        chk("block_halt_ready",  s_lr,     64'd1);
        chk("block_halt_stable", s_stable, 64'd1);
        chk("block_halt_gen",    s_gen,    64'd0);
        chk("block_halt_grid",   s_grid,   block);
        chk("block_halt_gv",     64'(gv_cnt), 64'd0);
        set_in(0, 1'b0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Priority: load+run+step together in IDLE -> load only
        load(0, blink_h);
        gv_cnt = 0;
        do_step(0, gv_cnt);
        sample(0);
        chk("prio_pre_gen", s_gen, 64'd1);
        @(negedge clk);
        set_in(0, 1'b1, corners, 1'b1, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 64'd0, 1'b0, 1'b0);
        sample(0);
        chk("prio_grid",   s_grid,   corners);
        chk("prio_gen",    s_gen,    64'd0);
        chk("prio_busy",   s_busy,   64'd0);
        chk("prio_stable", s_stable, 64'd0);
        @(negedge clk);
        sample(0);
        chk("prio_idle_busy", s_busy, 64'd0);
        chk("prio_idle_grid", s_grid, corners);

        // Saturation with a 2-bit counter
        load(2, blink_h);
        set_in(2, 1'b0, 64'd0, 1'b0, 1'b1);
        gv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            sample(2);
            if (s_gv) gv_cnt++;
        end
        chk("sat_gen",    s_gen,    64'd3);
        chk("sat_stable", s_stable, 64'd0);
        chk("sat_ready",  s_lr,     64'd1);
        chk("sat_busy",   s_busy,   64'd0);
        chk("sat_grid",   s_grid,   blink_v);
        chk("sat_gv",     64'(gv_cnt), 64'd3);
        set_in(2, 1'b0, 64'd0, 1'b0, 1'b0);

        // Glider on the torus returns to its seed after 32 generations
        load(1, glider);
        set_in(1, 1'b0, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        sample(1);
        chk("glider_lat_gen",  s_gen,  64'd0);
        chk("glider_lat_busy", s_busy, 64'd1);
        gv_cnt = 0;
        repeat (32) begin
            @(negedge clk);
            sample(1);
            if (s_gv) gv_cnt++;
        end
        chk("glider_grid",   s_grid,   glider);
        chk("glider_gen",    s_gen,    64'd32);
        chk("glider_busy",   s_busy,   64'd1);
        chk("glider_stable", s_stable, 64'd0);
        chk("glider_gv",     64'(gv_cnt), 64'd32);

        // Load offered during RUN is refused
        set_in(1, 1'b1, 64'd0, 1'b0, 1'b1);
        sample(1);
        chk("run_ready", s_lr, 64'd0);
        @(negedge clk);
        set_in(1, 1'b0, 64'd0, 1'b0, 1'b1);
        sample(1);
        chk("run_noload_gen",     s_gen, 64'd33);
        chk("run_noload_extinct", s_ext, 64'd0);

        // Asynchronous reset mid-RUN, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        sample(1);
        chk("arst_grid",    s_grid,   64'd0);
        chk("arst_gen",     s_gen,    64'd0);
        chk("arst_gv",      s_gv,     64'd0);
        chk("arst_busy",    s_busy,   64'd0);
        chk("arst_stable",  s_stable, 64'd0);
        chk("arst_extinct", s_ext,    64'd1);
        chk("arst_ready",   s_lr,     64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised, clocked successor to the fixed 8x8 combinational Game of Life evolve datapath.
- Holds an R x C cell grid in a register and computes the next generation each cycle it advances. Generations advance by single step or free-run.
- Configurable edge mode (dead border or torus) and configurable birth/survive rule masks.
- Reports a generation count and stable/extinct status to the controller, and accepts new seed grids through a valid/ready load port.

Parameters:
- ROWS, 8, grid height in cells (>=3)
- COLS, 8, grid width in cells (>=3)
- WRAP, 0, edge mode: 0 = cells outside the grid count as dead; 1 = toroidal wrap (row/column indices taken modulo ROWS/COLS)
- BIRTH_MASK, 9'b000001000, bit n set = a dead cell with n live neighbours is born (default B3)
- SURVIVE_MASK, 9'b000001100, bit n set = a live cell with n live neighbours survives (default S23)
- GEN_W, 16, generation counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  seed grid offered
- load_ready  out  1  engine can accept a seed
- load_grid  in  ROWS*COLS  seed; cell (r,c) = bit r*COLS+c
- step  in  1  single-cycle pulse: advance one generation
- run  in  1  level: advance one generation per cycle while high
- grid_out  out  ROWS*COLS  current grid register
- gen_count  out  GEN_W  generations advanced since last load
- gen_valid  out  1  one-cycle pulse, registered, after each advance
- busy  out  1  high in RUN
- stable  out  1  last attempted advance produced an identical grid
- extinct  out  1  grid register is all zero

Behaviour:
- Reset (rst low, asynchronous): grid_out=0, gen_count=0, gen_valid=0, busy=0, stable=0, extinct=1, state=IDLE.
- Next-state function (combinational, from grid_out):
  - Neighbour count n is 0..8, 4 bits, over the 8 Moore neighbours per WRAP.
  - nxt(cell) = cur ? SURVIVE_MASK[n] : BIRTH_MASK[n].
- States:
  - IDLE: load_ready=1, busy=0.
  - RUN: load_ready=0, busy=1.
  - HALT: load_ready=1, busy=0.
- Advance (one cycle, registered):
  - Performed only if nxt != grid_out and gen_count != all-ones.
  - grid_out <= nxt, gen_count += 1, gen_valid=1 next cycle, stable <= 0, extinct <= (nxt==0).
- Blocked advance: if nxt == grid_out, stable <= 1. Grid, gen_count and gen_valid are unchanged.
- IDLE transitions:
  - load handshake (valid&ready): grid_out <= load_grid, gen_count <= 0, stable <= 0, extinct <= (load_grid==0); stay IDLE.
  - else run=1: go RUN, no advance this cycle.
  - else step=1: attempt one advance, stay IDLE.
  - Load has priority over run; run has priority over step.
- RUN transitions:
  - Each cycle: if run=0, go IDLE with no advance.
  - elif nxt == grid_out: stable <= 1, go HALT.
  - elif gen_count == all-ones: go HALT, stable stays 0 (saturation).
  - else advance.
  - step is ignored in RUN.
- HALT transitions:
  - load handshake: as in IDLE, go IDLE.
  - elif run=0: go IDLE.
  - step is ignored.
- Latency: first advance occurs on the second rising edge after run rises. grid_out is valid on the same edge that gen_valid asserts.
- Reset mid-RUN: immediate return to reset values; the in-flight generation is discarded.
- load_valid in RUN: not accepted; the offering side holds load_grid until ready.

Test Plan:
- Blinker, 8x8, WRAP=0:
  - Load bits {26,27,28}, pulse step -> grid_out={19,27,35}, gen_count=1, gen_valid one pulse.
  - Step again -> {26,27,28}, gen_count=2.
- Block still life {27,28,35,36}, run=1 -> HALT within 2 cycles, stable=1, gen_count=0, gen_valid never pulses.
- Corners {0,7,56,63}, step:
  - WRAP=0 -> grid_out=0, extinct=1, gen_count=1.
  - WRAP=1 -> grid unchanged (torus block), stable=1, gen_count=0.
- Glider {1,10,16,17,18}, WRAP=1, run held:
  - After 32 advances grid_out equals the seed; gen_count=32; busy stays 1.
- Saturation, GEN_W=2, blinker, run held -> 3 advances, then HALT with gen_count=3, stable=0, load_ready=1.
- Priority and reset:
  - load_valid+run+step in the same IDLE cycle -> load only, gen_count=0, state IDLE.
  - Assert rst low mid-RUN -> all outputs reach reset values without waiting for a clock edge.
